// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM pipeline stage with pointer registers, req/ack memory handshake, forwarding and timeout.
//   Build option: STACK_LIMIT_CHECK_EN enables the stack-limit guard on pointer NUM_PTRS-1.
//   Ports: clock/reset (async, active-high); ex_* op from EX/MEM with ex_ready stall;
//   mem_* req/ack memory port; wb_valid/wb_out result to MEM/WB; ptr_out all pointers packed;
//   timeout_err and stack_ovf sticky error flags.
module mem_access_stage #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 16,
  parameter int NUM_PTRS = 4,
  parameter int PTR_SEL_W = 2,
  parameter logic [ADDR_W-1:0] STACK_RESET = '1,
  parameter int TIMEOUT_CYC = 64
`ifdef STACK_LIMIT_CHECK_EN
  , parameter logic [ADDR_W-1:0] STACK_LIMIT = ADDR_W'(16'h0100)
`endif
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       ex_valid,
  output logic                       ex_ready,
  input  logic [1:0]                 ex_op,
  input  logic [PTR_SEL_W-1:0]       ex_ptr_sel,
  input  logic [1:0]                 ex_ptr_mode,
  input  logic [1:0]                 ex_fwd_sel,
  input  logic [DATA_W-1:0]          ex_data,
  input  logic [DATA_W-1:0]          wb_data,
  input  logic [DATA_W-1:0]          wb_tm1_data,
  input  logic                       ex_ptr_wren,
  input  logic [ADDR_W-1:0]          ex_ptr_wdata,
  output logic                       mem_req,
  output logic                       mem_we,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic [DATA_W-1:0]          mem_wdata,
  input  logic                       mem_ack,
  input  logic [DATA_W-1:0]          mem_rdata,
  output logic                       wb_valid,
  output logic [DATA_W-1:0]          wb_out,
  output logic [NUM_PTRS*ADDR_W-1:0] ptr_out,
  output logic                       timeout_err,
  output logic                       stack_ovf
);
  typedef enum logic {IDLE, ACCESS} state_t;
  state_t state, state_nxt;
  logic [ADDR_W-1:0] ptr [NUM_PTRS];
  logic [ADDR_W-1:0] cur, ea;
  logic [DATA_W-1:0] fwd, a_data;
  logic [PTR_SEL_W-1:0] a_sel;
  logic [1:0] a_mode;
  logic a_load;
  logic [31:0] cnt;
  logic acc, is_mem, hit, start, done, abort, tmo;
  assign ex_ready = state == IDLE;
  assign acc = ex_valid & ex_ready;
  assign is_mem = ex_op[0] ^ ex_op[1];
  assign cur = ptr[ex_ptr_sel];
  assign ea = ex_ptr_mode == 2'b10 ? cur - ADDR_W'(1) : cur;
  assign fwd = ex_fwd_sel == 2'b00 ? ex_data : ex_fwd_sel == 2'b01 ? wb_data : wb_tm1_data;
  // cnt holds (cycles spent in ACCESS - 1), so the abort lands on the TIMEOUT_CYC-th cycle.
  assign tmo = (TIMEOUT_CYC != 0) && (cnt == 32'(TIMEOUT_CYC - 1));
  assign start = acc & is_mem & ~hit;
  assign done = (state == ACCESS) & mem_ack;
  assign abort = (state == ACCESS) & ~mem_ack & tmo;
`ifdef STACK_LIMIT_CHECK_EN
  assign hit = acc & is_mem & (ex_ptr_sel == PTR_SEL_W'(NUM_PTRS - 1)) & (ea < STACK_LIMIT);
  always_ff @(posedge clock or posedge reset)
    if (reset) stack_ovf <= 1'b0;
    else if (hit) stack_ovf <= 1'b1;
`else
  assign hit = 1'b0;
  assign stack_ovf = 1'b0;
`endif
  always_comb begin
    state_nxt = state;
    state_nxt = state == IDLE ? (start ? ACCESS : IDLE) : (mem_ack | tmo) ? IDLE : ACCESS;
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_nxt;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mem_req <= 1'b0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      wb_valid <= 1'b0;
      wb_out <= '0;
      timeout_err <= 1'b0;
      cnt <= '0;
      a_data <= '0;
      a_sel <= '0;
      a_mode <= '0;
      a_load <= 1'b0;
      for (int i = 0; i < NUM_PTRS; i++) ptr[i] <= (i == NUM_PTRS - 1) ? STACK_RESET : '0;
    end else begin
      wb_valid <= 1'b0;
      if (acc & (~is_mem | hit)) begin
        // Pass op, or a load/store squashed by the stack guard: single-cycle result.
        wb_valid <= 1'b1;
        wb_out <= is_mem ? '0 : ex_data;
        if (~is_mem & ex_ptr_wren) ptr[ex_ptr_sel] <= ex_ptr_wdata;
      end
      if (start) begin
        mem_req <= 1'b1;
        mem_we <= ex_op == 2'b10;
        mem_addr <= ea;
        mem_wdata <= fwd;
        a_data <= ex_data;
        a_sel <= ex_ptr_sel;
        a_mode <= ex_ptr_mode;
        a_load <= ex_op == 2'b01;
        cnt <= '0;
      end
      if (state == ACCESS) cnt <= cnt + 32'd1;
      if (done) begin
        mem_req <= 1'b0;
        mem_we <= 1'b0;
        wb_valid <= 1'b1;
        wb_out <= a_load ? mem_rdata : a_data;
        if (a_mode == 2'b01) ptr[a_sel] <= ptr[a_sel] + ADDR_W'(1);
        else if (a_mode == 2'b10) ptr[a_sel] <= ptr[a_sel] - ADDR_W'(1);
      end
      if (abort) begin
        mem_req <= 1'b0;
        mem_we <= 1'b0;
        wb_valid <= 1'b1;
        wb_out <= '0;
        timeout_err <= 1'b1;
      end
    end
  end
  for (genvar i = 0; i < NUM_PTRS; i++) begin : g_ptr
    assign ptr_out[i*ADDR_W +: ADDR_W] = ptr[i];
  end
endmodule
